mbus_tx_arbiter: RTL and testbench

Shares one MBus layer TX port (TX_ADDR/TX_DATA/TX_REQ/TX_ACK/TX_PEND/PRIORITY/TX_SUCC/TX_FAIL/TX_RESP_ACK) among NUM_REQ local requesters on the same layer controller. It sequences each requester's multi-word message through the layer's four-phase TX handshake. It collects the TX_SUCC/TX_FAIL result, acknowledges it with TX_RESP_ACK, and returns the result to the originating requester. It sits between the layer's local bus clients and the mbus layer wrapper TX interface.

---
 rtl/mbus_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mbus_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbus_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mbus_tx_arbiter
//
// Shares one MBus layer TX port among NUM_REQ local requesters. A requester is
// chosen by priority-filtered round-robin, its message is walked word by word
// through the layer's four-phase TX_REQ/TX_ACK handshake, and the layer's
// TX_SUCC/TX_FAIL result is acknowledged with TX_RESP_ACK and reported back to
// the owning requester as a REQ_DONE or REQ_FAIL pulse.
//
// Optional feature macro: MBUS_TX_ARB_WATCHDOG_EN
//   When defined, a watchdog aborts a message whose owner leaves the arbiter
//   waiting for the next word for WDT_CYCLES cycles. The layer's eventual
//   result is then reported as a failure.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   REQ_VALID[i]          requester i has a word ready
//   REQ_ADDR / REQ_DATA   per-requester address / data, slice i
//   REQ_PEND[i]           more words follow the current one
//   REQ_PRIORITY[i]       requester i asks for priority arbitration
//   REQ_ACK / REQ_DONE / REQ_FAIL   per-requester 1-cycle pulses
//   GRANT                 index of the current owner
//   BUSY                  a message is in progress
//   TX_ADDR, TX_DATA, TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK   to the layer
//   TX_ACK, TX_SUCC, TX_FAIL                                   from the layer
// -----------------------------------------------------------------------------
module mbus_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WDT_CYCLES = 1024
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_REQ-1:0]           REQ_VALID,
  input  logic [NUM_REQ*ADDR_W-1:0]    REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0]    REQ_DATA,
  input  logic [NUM_REQ-1:0]           REQ_PEND,
  input  logic [NUM_REQ-1:0]           REQ_PRIORITY,
  output logic [NUM_REQ-1:0]           REQ_ACK,
  output logic [NUM_REQ-1:0]           REQ_DONE,
  output logic [NUM_REQ-1:0]           REQ_FAIL,
  output logic [$clog2(NUM_REQ)-1:0]   GRANT,
  output logic                         BUSY,
  output logic [ADDR_W-1:0]            TX_ADDR,
  output logic [DATA_W-1:0]            TX_DATA,
  output logic                         TX_REQ,
  output logic                         TX_PEND,
  output logic                         PRIORITY,
  input  logic                         TX_ACK,
  input  logic                         TX_SUCC,
  input  logic                         TX_FAIL,
  output logic                         TX_RESP_ACK
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND     = 3'd1;
  localparam logic [2:0] ACK_LOW  = 3'd2;
  localparam logic [2:0] NEXT     = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;
  localparam logic [2:0] RESP_CLR = 3'd5;

  logic [2:0]         state;
  logic [GW-1:0]      ptr;
  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [GW-1:0]      win_idx;
  int                 scan_pos;
  logic [GW-1:0]      scan_idx;
  logic [GW-1:0]      ptr_after;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  // Results that arrive before RESP are remembered so they are not lost if the
  // layer drops them before the arbiter gets there.
  logic lat_succ;
  logic lat_fail;
  logic res_any;
  logic res_fail;

  logic wdt_expire;
  logic wdt_abort;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = REQ_ADDR[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = REQ_DATA[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: first candidate at or after ptr, wrapping. Priority
  // requesters hide everyone else whenever at least one of them is valid.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    cand      = ((REQ_VALID & REQ_PRIORITY) != '0) ? (REQ_VALID & REQ_PRIORITY) : REQ_VALID;
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_pos = (int'(ptr) + k) % NUM_REQ;
      scan_idx = scan_pos[GW-1:0];
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    res_any   = TX_SUCC | TX_FAIL | lat_succ | lat_fail;
    res_fail  = TX_FAIL | lat_fail | wdt_abort;
    ptr_after = (GRANT == GW'(NUM_REQ - 1)) ? '0 : GRANT + 1'b1;
  end

`ifdef MBUS_TX_ARB_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_cnt;

  // Counter only advances while waiting in NEXT; being anywhere else clears
  // it, which restarts the count on every entry to NEXT.
  assign wdt_expire = (state == NEXT) && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wdt_cnt   <= '0;
      wdt_abort <= 1'b0;
    end else begin
      if (state == NEXT) wdt_cnt <= wdt_cnt + 1'b1;
      else               wdt_cnt <= '0;

      if (wdt_expire && !REQ_VALID[GRANT] && !TX_SUCC && !TX_FAIL) wdt_abort <= 1'b1;
      else if (state == IDLE)                                      wdt_abort <= 1'b0;
    end
  end
`else
  assign wdt_expire = 1'b0;
  assign wdt_abort  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      ptr         <= '0;
      lat_succ    <= 1'b0;
      lat_fail    <= 1'b0;
      REQ_ACK     <= '0;
      REQ_DONE    <= '0;
      REQ_FAIL    <= '0;
      GRANT       <= '0;
      BUSY        <= 1'b0;
      TX_ADDR     <= '0;
      TX_DATA     <= '0;
      TX_REQ      <= 1'b0;
      TX_PEND     <= 1'b0;
      PRIORITY    <= 1'b0;
      TX_RESP_ACK <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here, overridden below, give clean one-cycle pulses.
      REQ_ACK  <= '0;
      REQ_DONE <= '0;
      REQ_FAIL <= '0;

      case (state)
        IDLE: begin
          lat_succ <= 1'b0;
          lat_fail <= 1'b0;
          if (win_found) begin
            GRANT    <= win_idx;
            TX_ADDR  <= addr_arr[win_idx];
            TX_DATA  <= data_arr[win_idx];
            TX_PEND  <= REQ_PEND[win_idx];
            PRIORITY <= REQ_PRIORITY[win_idx];
            TX_REQ   <= 1'b1;
            BUSY     <= 1'b1;
            state    <= SEND;
          end
        end

        SEND: begin
          lat_succ <= lat_succ | TX_SUCC;
          lat_fail <= lat_fail | TX_FAIL;
          if (TX_ACK) begin
            TX_REQ         <= 1'b0;
            REQ_ACK[GRANT] <= 1'b1;
            state          <= ACK_LOW;
          end
        end

        ACK_LOW: begin
          lat_succ <= lat_succ | TX_SUCC;
          lat_fail <= lat_fail | TX_FAIL;
          if (!TX_ACK) begin
            // An early layer result ends the message without fetching more words.
            if (TX_PEND && !res_any) state <= NEXT;
            else                     state <= RESP;
          end
        end

        NEXT: begin
          lat_succ <= lat_succ | TX_SUCC;
          lat_fail <= lat_fail | TX_FAIL;
          if (TX_SUCC || TX_FAIL) begin
            state <= RESP;
          end else if (REQ_VALID[GRANT]) begin
            // Address was fixed by the first word; only data and PEND move.
            TX_DATA <= data_arr[GRANT];
            TX_PEND <= REQ_PEND[GRANT];
            TX_REQ  <= 1'b1;
            state   <= SEND;
          end else if (wdt_expire) begin
            state <= RESP;
          end
        end

        RESP: begin
          if (res_any) begin
            TX_RESP_ACK <= 1'b1;
            if (res_fail) REQ_FAIL[GRANT] <= 1'b1;
            else          REQ_DONE[GRANT] <= 1'b1;
            state <= RESP_CLR;
          end
        end

        RESP_CLR: begin
          if (!TX_SUCC && !TX_FAIL) begin
            TX_RESP_ACK <= 1'b0;
            BUSY        <= 1'b0;
            ptr         <= ptr_after;
            lat_succ    <= 1'b0;
            lat_fail    <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mbus_tx_arbiter
//
// Directed bench for mbus_tx_arbiter with NUM_REQ=4. Single-word messages come
// from a vector table carrying the expected grant; multi-word, abort-in-NEXT,
// reset-mid-SEND and (when the macro is defined) watchdog cases are written out
// by hand. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mbus_tx_arbiter;

  localparam int N = 4;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N-1:0]    REQ_VALID;
  logic [N*32-1:0] REQ_ADDR;
  logic [N*32-1:0] REQ_DATA;
  logic [N-1:0]    REQ_PEND;
  logic [N-1:0]    REQ_PRIORITY;
  logic [N-1:0]    REQ_ACK;
  logic [N-1:0]    REQ_DONE;
  logic [N-1:0]    REQ_FAIL;
  logic [1:0]      GRANT;
  logic            BUSY;
  logic [31:0]     TX_ADDR;
  logic [31:0]     TX_DATA;
  logic            TX_REQ;
  logic            TX_PEND;
  logic            PRIORITY;
  logic            TX_ACK;
  logic            TX_SUCC;
  logic            TX_FAIL;
  logic            TX_RESP_ACK;

  mbus_tx_arbiter #(
    .NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .WDT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_PEND(REQ_PEND), .REQ_PRIORITY(REQ_PRIORITY),
    .REQ_ACK(REQ_ACK), .REQ_DONE(REQ_DONE), .REQ_FAIL(REQ_FAIL),
    .GRANT(GRANT), .BUSY(BUSY),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_PEND(TX_PEND),
    .PRIORITY(PRIORITY), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .TX_RESP_ACK(TX_RESP_ACK)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // result: 1 = layer SUCC, 2 = layer FAIL, 3 = both (counts as fail)
  typedef struct {
    logic        rst_first;
    logic [3:0]  valid;
    logic [3:0]  prio;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  result;
    logic [1:0]  exp_grant;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic p);
    REQ_ADDR[i*32 +: 32] = a;
    REQ_DATA[i*32 +: 32] = d;
    REQ_PEND[i]          = p;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {REQ_ACK, REQ_DONE, REQ_FAIL, GRANT, BUSY, TX_REQ, TX_PEND, PRIORITY, TX_RESP_ACK}, 64'd0);
    check({tag, "_bus"}, {TX_ADDR, TX_DATA}, 64'd0);
  endtask

  // Starts with the DUT in SEND and TX_REQ high for a final (PEND=0) word;
  // completes the handshake and the response phase.
  task automatic finish_single(input logic [1:0] g, input logic [1:0] result);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    TX_ACK = 1'b1;
    tick;
    check("ack_drops_tx_req", TX_REQ, 0);
    check("req_ack_pulse", REQ_ACK, oh);
    TX_ACK    = 1'b0;
    REQ_VALID = REQ_VALID & ~oh;
    tick;
    check("req_ack_one_cycle", REQ_ACK, 0);
    check("no_early_resp_ack", TX_RESP_ACK, 0);
    TX_SUCC = result[0];
    TX_FAIL = result[1];
    tick;
    check("resp_ack_set", TX_RESP_ACK, 1);
    check("req_done", REQ_DONE, result[1] ? 4'b0000 : oh);
    check("req_fail", REQ_FAIL, result[1] ? oh : 4'b0000);
    tick;
    check("resp_ack_held", TX_RESP_ACK, 1);
    check("result_one_cycle", {REQ_DONE, REQ_FAIL}, 0);
    TX_SUCC = 1'b0;
    TX_FAIL = 1'b0;
    tick;
    check("resp_ack_clear", TX_RESP_ACK, 0);
    check("busy_clear", BUSY, 0);
  endtask

  task automatic single_msg(input vec_t v);
    if (v.rst_first) begin
      RESET = 1'b1;
      tick;
      RESET = 1'b0;
    end
    REQ_VALID    = v.valid;
    REQ_PRIORITY = v.prio;
    // Only the expected winner carries the table values, so a wrong grant
    // also shows up on TX_ADDR/TX_DATA.
    for (int i = 0; i < N; i++) begin
      if (i == int'(v.exp_grant)) set_req(i, v.addr, v.data, 1'b0);
      else                        set_req(i, ~v.addr, ~v.data, 1'b0);
    end
    tick;
    check("grant", GRANT, v.exp_grant);
    check("tx_req_set", TX_REQ, 1);
    check("busy_set", BUSY, 1);
    check("tx_addr", TX_ADDR, v.addr);
    check("tx_data", TX_DATA, v.data);
    check("tx_pend", TX_PEND, 0);
    check("priority", PRIORITY, v.prio[v.exp_grant]);
    tick;
    check("tx_req_hold", TX_REQ, 1);
    check("no_ack_before_tx_ack", REQ_ACK, 0);
    finish_single(v.exp_grant, v.result);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Pointer evolution noted per entry (value before -> after).
    vecs[0]  = '{1'b0, 4'b0010, 4'b0000, 32'h0000_00A5, 32'hDEAD_BEEF, 2'd1, 2'd1}; // 0 -> 2
    vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 32'h1000_0000, 32'hA000_0000, 2'd1, 2'd0}; // reset 0 -> 1
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 32'h1000_0001, 32'hA000_0001, 2'd1, 2'd1}; // 1 -> 2
    vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 32'h1000_0002, 32'hA000_0002, 2'd1, 2'd2}; // 2 -> 3
    vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 32'h1000_0003, 32'hA000_0003, 2'd1, 2'd3}; // 3 -> 0
    vecs[5]  = '{1'b0, 4'b0011, 4'b0010, 32'h2000_0001, 32'hB000_0001, 2'd1, 2'd1}; // prio 0 -> 2
    vecs[6]  = '{1'b0, 4'b0001, 4'b0000, 32'h2000_0000, 32'hB000_0000, 2'd1, 2'd0}; // 2 -> 1
    vecs[7]  = '{1'b0, 4'b1000, 4'b0000, 32'h3000_0003, 32'hC000_0003, 2'd2, 2'd3}; // fail 1 -> 0
    vecs[8]  = '{1'b0, 4'b0100, 4'b0000, 32'h3000_0002, 32'hC000_0002, 2'd3, 2'd2}; // both 0 -> 3
    vecs[9]  = '{1'b0, 4'b0101, 4'b0000, 32'h4000_0000, 32'hD000_0000, 2'd1, 2'd0}; // wrap 3 -> 1
    vecs[10] = '{1'b0, 4'b1111, 4'b1001, 32'h4000_0003, 32'hD000_0003, 2'd1, 2'd3}; // prio 1 -> 0

    RESET = 1'b1;
    REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0; REQ_PEND = '0; REQ_PRIORITY = '0;
    TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
    @(negedge CLK);
    tick;
    check_all_zero("reset");
    RESET = 1'b0;
    tick;
    check_all_zero("idle_no_req");

    foreach (vecs[i]) single_msg(vecs[i]);

    // Multi-word message from requester 2 (pointer 0); requester 0 shows up mid-message.
    REQ_VALID = '0; REQ_PRIORITY = '0;
    set_req(2, 32'h0000_C0DE, 32'h1111_1111, 1'b1);
    REQ_VALID = 4'b0100;
    tick;
    check("mw_grant", GRANT, 2);
    check("mw1_tx_req", TX_REQ, 1);
    check("mw1_data", TX_DATA, 32'h1111_1111);
    check("mw1_pend", TX_PEND, 1);
    check("mw1_addr", TX_ADDR, 32'h0000_C0DE);
    TX_ACK = 1'b1;
    tick;
    check("mw1_req_ack", REQ_ACK, 4'b0100);
    set_req(2, 32'hBAD0_0000, 32'h2222_2222, 1'b1);
    set_req(0, 32'h0000_0A0A, 32'h0A0A_0A0A, 1'b0);
    REQ_VALID = 4'b0101;
    TX_ACK = 1'b0;
    tick;
    check("mw_gap_tx_req", TX_REQ, 0);
    tick;
    check("mw2_tx_req", TX_REQ, 1);
    check("mw2_data", TX_DATA, 32'h2222_2222);
    check("mw2_addr_kept", TX_ADDR, 32'h0000_C0DE);
    check("mw2_pend", TX_PEND, 1);
    check("mw2_grant_kept", GRANT, 2);
    TX_ACK = 1'b1;
    tick;
    check("mw2_req_ack", REQ_ACK, 4'b0100);
    set_req(2, 32'hBAD0_0000, 32'h3333_3333, 1'b0);
    TX_ACK = 1'b0;
    tick;
    tick;
    check("mw3_tx_req", TX_REQ, 1);
    check("mw3_data", TX_DATA, 32'h3333_3333);
    check("mw3_pend", TX_PEND, 0);
    check("mw3_addr_kept", TX_ADDR, 32'h0000_C0DE);
    TX_ACK = 1'b1;
    tick;
    check("mw3_req_ack", REQ_ACK, 4'b0100);
    TX_ACK = 1'b0;
    REQ_VALID = 4'b0001;
    tick;
    check("mw_resp_grant", GRANT, 2);
    check("mw_resp_no_tx_req", TX_REQ, 0);
    TX_SUCC = 1'b1;
    tick;
    check("mw_done", REQ_DONE, 4'b0100);
    check("mw_resp_ack", TX_RESP_ACK, 1);
    TX_SUCC = 1'b0;
    tick;
    check("mw_busy_clear", BUSY, 0);
    check("mw_idle_gap", TX_REQ, 0);
    tick;
    check("mw_then_req0_grant", GRANT, 0);
    check("mw_then_req0_tx_req", TX_REQ, 1);
    check("mw_then_req0_addr", TX_ADDR, 32'h0000_0A0A);
    finish_single(2'd0, 2'd1); // pointer -> 1

    // Layer aborts with TX_FAIL while waiting for word 2 of requester 1.
    set_req(1, 32'h0000_1234, 32'h5555_5555, 1'b1);
    REQ_VALID = 4'b0010;
    tick;
    check("nf_grant", GRANT, 1);
    check("nf_tx_req", TX_REQ, 1);
    TX_ACK = 1'b1;
    tick;
    check("nf_req_ack", REQ_ACK, 4'b0010);
    TX_ACK = 1'b0;
    REQ_VALID = '0;
    tick;
    tick;
    check("nf_waiting_no_tx_req", TX_REQ, 0);
    check("nf_waiting_busy", BUSY, 1);
    TX_FAIL = 1'b1;
    tick;
    check("nf_resp_ack_not_yet", TX_RESP_ACK, 0);
    tick;
    check("nf_resp_ack", TX_RESP_ACK, 1);
    check("nf_req_fail", REQ_FAIL, 4'b0010);
    check("nf_no_done", REQ_DONE, 4'b0000);
    TX_FAIL = 1'b0;
    tick;
    check("nf_busy_clear", BUSY, 0);
    tick;
    check("nf_no_more_tx_req", TX_REQ, 0); // pointer -> 2

    // Reset while TX_REQ is high, then a fresh request starts from pointer 0.
    set_req(3, 32'h0000_3333, 32'h0303_0303, 1'b0);
    REQ_VALID = 4'b1000;
    tick;
    check("rs_grant", GRANT, 3);
    check("rs_tx_req", TX_REQ, 1);
    RESET = 1'b1;
    tick;
    check_all_zero("rs_mid_send");
    RESET = 1'b0;
    set_req(1, 32'h0000_A5A5, 32'h0000_0077, 1'b0);
    REQ_VALID = 4'b1010;
    tick;
    check("rs_regrant_from_zero", GRANT, 1);
    check("rs_regrant_tx_req", TX_REQ, 1);
    check("rs_regrant_data", TX_DATA, 32'h0000_0077);
    finish_single(2'd1, 2'd1); // pointer -> 2

`ifdef MBUS_TX_ARB_WATCHDOG_EN
    // Word 2 withheld: abort after 16 cycles in NEXT, later SUCC reports as fail.
    REQ_VALID = '0;
    set_req(3, 32'h0000_F00D, 32'h0000_0001, 1'b1);
    REQ_VALID = 4'b1000;
    tick;
    check("wd_grant", GRANT, 3);
    TX_ACK = 1'b1;
    tick;
    TX_ACK = 1'b0;
    REQ_VALID = '0;
    tick;
    repeat (16) tick;
    check("wd_no_tx_req", TX_REQ, 0);
    TX_SUCC = 1'b1;
    tick;
    check("wd_abort_fail", REQ_FAIL, 4'b1000);
    check("wd_abort_no_done", REQ_DONE, 4'b0000);
    TX_SUCC = 1'b0;
    tick;
    check("wd_busy_clear", BUSY, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
